// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit with HI/LO registers and its own busy sequencer.
//
// Sits in the E stage beside the ALU. Each start pulse carrying a mult/multu/
// div/divu computes the 64-bit result at the accepting edge. The result is held
// in shadow registers while a counter models the multi-cycle latency. HI/LO are
// written on the edge that ends the busy period. mthi/mtlo write HI/LO directly
// in a single cycle.
//
// Ports:
//   clk       in   1   system clock
//   reset     in   1   synchronous, active-high reset
//   start     in   1   op in E is an MDU operation (qualified by op)
//   op        in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   a         in  32   forwarded rs value
//   b         in  32   forwarded rt value
//   md_in_d   in   1   instruction in D uses HI/LO
//   busy      out  1   a mult/div is in progress
//   md_stall  out  1   stall request to the hazard unit
//   hi        out 32   HI register
//   lo        out 32   LO register
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_in_d,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_res_hi;
  logic [31:0]      r_res_lo;
  logic             r_res_keep;  // divide by zero: leave HI/LO untouched at commit
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic w_busy;
  logic w_accept;
  logic w_commit;
  logic w_mthi;
  logic w_mtlo;

  // ---------------------------------------------------------------------------
  // Operation decode
  // ---------------------------------------------------------------------------
  logic w_op_md;
  logic w_is_mult;
  logic w_is_signed;

  assign w_op_md     = start && (op == OP_MULT || op == OP_MULTU ||
                                 op == OP_DIV  || op == OP_DIVU);
  assign w_is_mult   = (op == OP_MULT) || (op == OP_MULTU);
  assign w_is_signed = (op == OP_MULT) || (op == OP_DIV);

  // ---------------------------------------------------------------------------
  // Arithmetic (evaluated on the accepting edge only)
  // ---------------------------------------------------------------------------
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  assign w_prod_s = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  // Signed division runs on magnitudes so that -2^31 / -1 stays well defined
  // (wraps to 0x80000000) instead of relying on tool-specific overflow.
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_div_zero;

  assign w_a_neg    = w_is_signed && a[31];
  assign w_b_neg    = w_is_signed && b[31];
  assign w_a_mag    = w_a_neg ? (32'd0 - a) : a;
  assign w_b_mag    = w_b_neg ? (32'd0 - b) : b;
  assign w_div_zero = (b == 32'd0);
  assign w_b_safe   = w_div_zero ? 32'd1 : w_b_mag;
  assign w_q_mag    = w_a_mag / w_b_safe;
  assign w_r_mag    = w_a_mag % w_b_safe;
  // Quotient truncates toward zero; remainder takes the dividend's sign.
  assign w_quot     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  logic [31:0] w_calc_hi;
  logic [31:0] w_calc_lo;

  always_comb begin
    w_calc_hi = w_rem;
    w_calc_lo = w_quot;
    if (op == OP_MULT) begin
      w_calc_hi = w_prod_s[63:32];
      w_calc_lo = w_prod_s[31:0];
    end else if (op == OP_MULTU) begin
      w_calc_hi = w_prod_u[63:32];
      w_calc_lo = w_prod_u[31:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    w_mthi       = 1'b0;
    w_mtlo       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_op_md) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
        w_mthi = start && (op == OP_MTHI);
        w_mtlo = start && (op == OP_MTLO);
      end
      RUN: begin
        // Any start seen here is ignored; the hazard unit should prevent it.
        w_busy = 1'b1;
        if (r_count == '0) begin
          w_commit     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter, result shadow and HI/LO registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_res_hi   <= '0;
      r_res_lo   <= '0;
      r_res_keep <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      if (w_accept) begin
        r_count    <= w_is_mult ? MULT_LOAD : DIV_LOAD;
        r_res_hi   <= w_calc_hi;
        r_res_lo   <= w_calc_lo;
        r_res_keep <= !w_is_mult && w_div_zero;
      end else if (w_busy && r_count != '0) begin
        r_count <= r_count - 1'b1;
      end

      if (w_commit && !r_res_keep) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end
      if (w_mthi) begin
        r_hi <= a;
      end
      if (w_mtlo) begin
        r_lo <= a;
      end
    end
  end

  // The start term lets the D-stage instruction stall in the same cycle a
  // mult/div is launched, before busy has had a chance to rise.
  assign md_stall = md_in_d && (w_busy || w_op_md);
  assign busy     = w_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
